// File: rtl/comm_tx.sv
// comm_tx: transmit modulator for the two-channel DAC/ADC link.
//
// Pops one 128-bit word from a first-word-fall-through FIFO per frame, sends
// a preamble of alternating full-scale symbols, and then sends the word as
// multi-level symbols on two 6-bit DAC buses, LSB first on each channel.
// A frame ends with a short run of mid-scale idle cycles.
//
// Ports:
//   CLK          system clock
//   RST          synchronous, active-high reset
//   enable       permits starting a new frame (sampled only in IDLE)
//   rd_en        FIFO pop strobe; din is captured at the same edge
//   din[127:0]   FIFO head word (valid while empty=0)
//   empty        FIFO empty flag
//   da1[5:0]     DAC code, channel 1 (carries din[63:0])
//   da2[5:0]     DAC code, channel 2 (carries din[127:64])
//   busy         high from the cycle after capture to the end of the gap
//   frame_start  one-cycle pulse during the first preamble cycle
//   fsm_state    current FSM state (0 IDLE, 1 PRE, 2 DATA, 3 GAP), for debug
//
// FIFO handshake: a word moves when rd_en is high at a rising CLK edge.
// rd_en is raised only in IDLE, with enable=1, empty=0 and RST=0, so it is
// high for at most one cycle per frame; the FIFO must present the next head
// word on din in the cycle following the pop.
module comm_tx #(
    parameter int modtype      = 1,  // 0: 1 bit/symbol, 1: 2 bits/symbol
    parameter int sym_cycles   = 4,  // cycles each symbol is held
    parameter int preamble_len = 8,  // preamble symbols (even, >= 2)
    parameter int gap_cycles   = 2   // idle cycles after each frame
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         enable,
    output logic         rd_en,
    input  logic [127:0] din,
    input  logic         empty,
    output logic [5:0]   da1,
    output logic [5:0]   da2,
    output logic         busy,
    output logic         frame_start,
    output logic [1:0]   fsm_state
);

    localparam int N_SYM   = (modtype != 0) ? 32 : 64;
    localparam int STEP    = (modtype != 0) ? 2 : 1;
    localparam int MAX_IDX = (preamble_len > N_SYM) ? preamble_len : N_SYM;
    localparam int IW      = $clog2(MAX_IDX);
    localparam int SW      = (sym_cycles > 1) ? $clog2(sym_cycles) : 1;
    localparam int GW      = (gap_cycles > 1) ? $clog2(gap_cycles) : 1;

    localparam logic [SW-1:0] SYM_LAST  = SW'(sym_cycles - 1);
    localparam logic [IW-1:0] PRE_LAST  = IW'(preamble_len - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(N_SYM - 1);
    // Only reachable when gap_cycles >= 1.
    localparam logic [GW-1:0] GAP_LAST  = GW'(gap_cycles - 1);

    localparam logic [5:0] CODE_IDLE = 6'd32;
    localparam logic [5:0] CODE_HIGH = 6'd63;
    localparam logic [5:0] CODE_LOW  = 6'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t        state;
    logic [127:0]  sr;        // {channel 2 bits, channel 1 bits}, LSB is next
    logic [SW-1:0] sym_cnt;   // cycle within the current symbol
    logic [IW-1:0] idx;       // symbol index within PRE or DATA
    logic [GW-1:0] gap_cnt;

    logic [63:0]   ch1_next;
    logic [63:0]   ch2_next;

    // Symbol level for the low bits of a channel. The 2-bit levels sit at
    // the centres of four equal bands: {value, 4'b1000}.
    function automatic logic [5:0] map_sym(input logic [1:0] bits);
        if (modtype == 0) begin
            return bits[0] ? 6'd48 : 6'd16;
        end else begin
            return {bits, 4'b1000};
        end
    endfunction

    // Register contents after the next symbol boundary shift.
    assign ch1_next = sr[63:0]   >> STEP;
    assign ch2_next = sr[127:64] >> STEP;

    assign rd_en     = (state == IDLE) && enable && !empty && !RST;
    assign fsm_state = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            sr          <= '0;
            sym_cnt     <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            da1         <= CODE_IDLE;
            da2         <= CODE_IDLE;
            busy        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en) begin
                        // The first preamble symbol is loaded at the capture
                        // edge so it appears in the very next cycle.
                        sr          <= din;
                        state       <= PRE;
                        sym_cnt     <= '0;
                        idx         <= '0;
                        da1         <= CODE_HIGH;
                        da2         <= CODE_HIGH;
                        busy        <= 1'b1;
                        frame_start <= 1'b1;
                    end
                end

                PRE: begin
                    frame_start <= 1'b0;
                    if (sym_cnt == SYM_LAST) begin
                        sym_cnt <= '0;
                        if (idx == PRE_LAST) begin
                            idx   <= '0;
                            state <= DATA;
                            da1   <= map_sym(sr[1:0]);
                            da2   <= map_sym(sr[65:64]);
                        end else begin
                            idx <= idx + 1'b1;
                            // Next symbol is idx+1: odd indices are low.
                            da1 <= idx[0] ? CODE_HIGH : CODE_LOW;
                            da2 <= idx[0] ? CODE_HIGH : CODE_LOW;
                        end
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (sym_cnt == SYM_LAST) begin
                        sym_cnt <= '0;
                        if (idx == DATA_LAST) begin
                            idx <= '0;
                            da1 <= CODE_IDLE;
                            da2 <= CODE_IDLE;
                            if (gap_cycles == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                            sr  <= {ch2_next, ch1_next};
                            da1 <= map_sym(ch1_next[1:0]);
                            da2 <= map_sym(ch2_next[1:0]);
                        end
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comm_tx.sv
// tb_comm_tx: directed bench for comm_tx.
// Instance u_a runs the default parameters and is fed from a FIFO model;
// instance u_b runs modtype=0, sym_cycles=2, preamble_len=4, gap_cycles=0
// from a constant word.
module tb_comm_tx;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instance A (defaults)
    logic         rst_a, enable_a, rd_en_a, empty_a, busy_a, fs_a;
    logic [127:0] din_a;
    logic [5:0]   da1_a, da2_a;
    logic [1:0]   st_a;

    // Instance B (modtype 0 configuration)
    logic         rst_b, enable_b, rd_en_b, empty_b, busy_b, fs_b;
    logic [127:0] din_b;
    logic [5:0]   da1_b, da2_b;
    logic [1:0]   st_b;

    comm_tx u_a (
        .CLK(CLK), .RST(rst_a), .enable(enable_a), .rd_en(rd_en_a),
        .din(din_a), .empty(empty_a), .da1(da1_a), .da2(da2_a),
        .busy(busy_a), .frame_start(fs_a), .fsm_state(st_a)
    );

    comm_tx #(
        .modtype(0), .sym_cycles(2), .preamble_len(4), .gap_cycles(0)
    ) u_b (
        .CLK(CLK), .RST(rst_b), .enable(enable_b), .rd_en(rd_en_b),
        .din(din_b), .empty(empty_b), .da1(da1_b), .da2(da2_b),
        .busy(busy_b), .frame_start(fs_b), .fsm_state(st_b)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0]  cyc = 0;
    logic [127:0] fifo_q[$];
    logic [31:0]  rd_log[$];
    logic [31:0]  exp_q[$];
    logic [5:0]   hist1[0:163];
    logic [5:0]   hist2[0:163];

    localparam logic [127:0] W0 = {64'h0, 64'h1B};
    localparam logic [127:0] W1 = {64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    localparam logic [127:0] W2 = {64'hAAAA_5555_F0F0_0F0F, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [127:0] W3 = {64'h1111_2222_3333_4444, 64'h8000_0000_0000_0001};
    localparam logic [127:0] W4 = {64'hDEAD_BEEF_DEAD_BEEF, 64'hCAFE_F00D_CAFE_F00D};
    localparam logic [127:0] W5 = {64'h0F1E_2D3C_4B5A_6978, 64'h9C00_0000_0000_00E4};

    // ---------------- scoreboard / checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // FIFO model: pop at the edge where rd_en is seen, log pop cycles.
    always @(posedge CLK) begin
        if (rd_en_a) begin
            rd_log.push_back(cyc);
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        cyc = cyc + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic update_fifo();
        empty_a = (fifo_q.size() == 0);
        // When empty, din carries junk that must never be sent.
        din_a = empty_a ? {$urandom, $urandom, $urandom, $urandom} : fifo_q[0];
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        update_fifo();
    endtask

    // Called in the rd_en cycle of a default-parameter frame; returns in
    // cycle 163 relative to it (the next IDLE decision cycle).
    task automatic run_frame(input logic [127:0] w, input int drop_at, input logic end_rd);
        int lut[4];
        int sym;
        int k;
        logic [31:0] e1, e2;
        logic eb;
        lut = '{8, 24, 40, 56};
        for (int c = 1; c <= 163; c++) begin
            tick();
            if (c == drop_at) enable_a = 1'b0;
            if (c <= 32) begin
                sym = (c - 1) / 4;
                e1 = (sym % 2 == 0) ? 63 : 0;
                e2 = e1;
                eb = 1'b1;
            end else if (c <= 160) begin
                k  = (c - 1) / 4 - 8;
                e1 = lut[w[2*k +: 2]];
                e2 = lut[w[64 + 2*k +: 2]];
                eb = 1'b1;
            end else begin
                e1 = 32;
                e2 = 32;
                eb = (c <= 162);
            end
            hist1[c] = da1_a;
            hist2[c] = da2_a;
            check($sformatf("da1@%0d", c), da1_a, e1);
            check($sformatf("da2@%0d", c), da2_a, e2);
            check($sformatf("busy@%0d", c), busy_a, eb);
            check($sformatf("frame_start@%0d", c), fs_a, c == 1);
            check($sformatf("rd_en@%0d", c), rd_en_a, (c == 163) ? end_rd : 1'b0);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_a = 1'b1; enable_a = 1'b1;
        rst_b = 1'b1; enable_b = 1'b1; empty_b = 1'b0;
        din_b = 128'h1;  // din[0]=1, din[64]=0
        fifo_q.push_back(W0);
        fifo_q.push_back(W1);
        fifo_q.push_back(W2);
        update_fifo();

        // Reset held 3 cycles with data available.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rd_en", rd_en_a, 0);
            check("rst_da1", da1_a, 32);
            check("rst_da2", da2_a, 32);
            check("rst_busy", busy_a, 0);
        end
        rst_a = 1'b0;
        #1;
        check("rd_en_after_rst", rd_en_a, 1);

        // Three back-to-back words.
        exp_q.push_back(cyc);
        exp_q.push_back(cyc + 163);
        exp_q.push_back(cyc + 326);
        run_frame(W0, 0, 1'b1);
        check("w0_da1@33", hist1[33], 56);
        check("w0_da1@37", hist1[37], 40);
        check("w0_da1@41", hist1[41], 24);
        check("w0_da1@45", hist1[45], 8);
        check("w0_da1@160", hist1[160], 8);
        check("w0_da2@33", hist2[33], 8);
        run_frame(W1, 0, 1'b1);
        run_frame(W2, 0, 1'b0);
        check("rd_count", rd_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rd_log.size(); i++)
            check($sformatf("rd_cycle%0d", i), rd_log[i], exp_q[i]);

        // FIFO empty: nothing starts.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("empty_rd_en", rd_en_a, 0);
            check("empty_da1", da1_a, 32);
            check("empty_busy", busy_a, 0);
        end

        // Enable dropped mid-frame: frame completes, no further pop.
        fifo_q.push_back(W3);
        fifo_q.push_back(W4);
        update_fifo();
        #1;
        check("flow_rd_en", rd_en_a, 1);
        run_frame(W3, 20, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("dis_rd_en", rd_en_a, 0);
        end
        check("fifo_left", fifo_q.size(), 1);

        // Reset at cycle 50 of a frame: W4 is dropped, W5 follows.
        fifo_q.push_back(W5);
        update_fifo();
        enable_a = 1'b1;
        #1;
        check("w4_rd_en", rd_en_a, 1);
        repeat (50) tick();
        check("mid_busy@50", busy_a, 1);
        rst_a = 1'b1;
        #1;
        check("mid_rst_rd_en", rd_en_a, 0);
        tick();
        check("mid_rst_da1", da1_a, 32);
        check("mid_rst_da2", da2_a, 32);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_rd_en2", rd_en_a, 0);
        rst_a = 1'b0;
        #1;
        check("w5_rd_en", rd_en_a, 1);
        run_frame(W5, 0, 1'b0);
        check("fifo_drained", fifo_q.size(), 0);

        // Instance B: modtype 0, 2-cycle symbols, 4 preamble, no gap.
        rst_b = 1'b0;
        #1;
        check("b_rd_en@0", rd_en_b, 1);
        for (int c = 1; c <= 274; c++) begin
            tick();
            case (c)
                1: begin
                    check("b_da1@1", da1_b, 63);
                    check("b_fs@1", fs_b, 1);
                    check("b_busy@1", busy_b, 1);
                end
                2: check("b_fs@2", fs_b, 0);
                3: check("b_da1@3", da1_b, 0);
                5: check("b_da2@5", da2_b, 63);
                8: check("b_da1@8", da1_b, 0);
                9: begin
                    check("b_da1@9", da1_b, 48);
                    check("b_da2@9", da2_b, 16);
                end
                10: begin
                    check("b_da1@10", da1_b, 48);
                    check("b_da2@10", da2_b, 16);
                end
                11: check("b_da1@11", da1_b, 16);
                136: begin
                    check("b_busy@136", busy_b, 1);
                    check("b_da1@136", da1_b, 16);
                    check("b_rd_en@136", rd_en_b, 0);
                end
                137: begin
                    check("b_busy@137", busy_b, 0);
                    check("b_da1@137", da1_b, 32);
                    check("b_rd_en@137", rd_en_b, 1);
                end
                138: begin
                    check("b_da1@138", da1_b, 63);
                    check("b_fs@138", fs_b, 1);
                end
                273: check("b_rd_en@273", rd_en_b, 0);
                274: check("b_rd_en@274", rd_en_b, 1);
                default: ;
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
